// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch unit and the control unit.
//   - Fetch FSM state encodings (3 bits).
//   - Instruction format codes carried in the low two bits of each instruction.
//   - Field positions for the format code and the J-type jump target.
package cpu_pkg;

  localparam int INSTR_W = 16;

  // Fetch FSM states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LATCH  = 3'd2;
  localparam logic [2:0] ST_DECODE = 3'd3;
  localparam logic [2:0] ST_EXEC   = 3'd4;
  localparam logic [2:0] ST_HALTED = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  // Instruction format codes
  localparam logic [1:0] FMT_R    = 2'b00;
  localparam logic [1:0] FMT_I    = 2'b01;
  localparam logic [1:0] FMT_J    = 2'b10;
  localparam logic [1:0] FMT_HALT = 2'b11;

  // Field positions: fmt is [FMT_MSB:FMT_LSB]; the jump target starts at
  // JT_LSB and is as wide as the program address.
  localparam int FMT_LSB = 0;
  localparam int FMT_MSB = 1;
  localparam int JT_LSB  = 5;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, reads 16-bit instructions
// from a synchronous ROM, resolves J-type jumps and HALT locally and issues
// R/I-type instructions to the control unit with a run/done handshake.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             one-cycle pulse, starts at address 0 from IDLE/HALTED
//   mem_en, mem_addr  ROM read request (data returns one cycle later)
//   mem_rdata         ROM read data
//   instruction       latched instruction register
//   run, done         execute strobe / completion from the control unit
//   pc                current program counter
//   busy, halted, error  status decoded from the state register
//   instr_count       issued instructions, saturating at 16'hFFFF
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               run,
  input  logic               done,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic               error,
  output logic [15:0]        instr_count
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] tmo_cnt;
  logic [1:0]       fmt;
  logic [ADDR_W-1:0] jump_target;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  assign fmt         = instruction[FMT_MSB:FMT_LSB];
  assign jump_target = instruction[JT_LSB +: ADDR_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= '0;
      instruction <= '0;
      instr_count <= '0;
      tmo_cnt     <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_HALTED: begin
          // Restart always begins at address 0; instr_count is kept.
          if (start) begin
            pc    <= '0;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_LATCH;
        ST_LATCH: begin
          instruction <= mem_rdata;
          state       <= ST_DECODE;
        end
        ST_DECODE: begin
          unique case (fmt)
            FMT_HALT: state <= ST_HALTED;
            FMT_J: begin
              pc    <= jump_target;
              state <= ST_FETCH;
            end
            FMT_R, FMT_I: begin
              tmo_cnt <= '0;
              state   <= ST_EXEC;
            end
          endcase
        end
        ST_EXEC: begin
          // done wins over the timeout in the same cycle.
          if (done) begin
            pc          <= pc + ADDR_W'(1);
            instr_count <= sat_inc16(instr_count);
            state       <= ST_FETCH;
          end else if (tmo_cnt == TMO_LAST) begin
            state <= ST_ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        ST_ERROR: state <= ST_ERROR;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // All outputs decode from registered state only; done never reaches run
  // combinationally.
  assign mem_en   = (state == ST_FETCH);
  assign mem_addr = mem_en ? pc : '0;
  assign run      = (state == ST_EXEC);
  assign busy     = (state == ST_FETCH) || (state == ST_LATCH) ||
                    (state == ST_DECODE) || (state == ST_EXEC);
  assign halted   = (state == ST_HALTED);
  assign error    = (state == ST_ERROR);

endmodule
